multi_port_sync_mem: RTL
========================

# multi_port_sync_mem

- Parametrised N-port synchronous RAM and the next generation of the team's two-port sync memory.
- Adds configurable port count, explicit read enables with a read-valid strobe, and a defined read-during-write mode.
- Resolves same-address write collisions deterministically.
- Runs a post-reset initialisation sweep that fills every word with a known value.
- Sits between datapath blocks and shared storage wherever several agents need single-cycle access to one array.

## Interface

Parameters:
- ADDR_WIDTH, 4, address bits per port; array holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.
- PORTS, 2, number of identical read/write ports (1..8).
- WRITE_FIRST, 0, read-during-write mode: 1 = new data, 0 = old data.
- INIT_VALUE, 0, DATA_WIDTH-wide value written to every word by the init sweep.

Ports (port p occupies slice p of each packed vector):
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ready  out  1  high when the init sweep is done and requests are accepted.
- writeEnable  in  PORTS  per-port write request.
- readEnable  in  PORTS  per-port read request.
- address  in  PORTS*ADDR_WIDTH  per-port word address.
- writeData  in  PORTS*DATA_WIDTH  per-port write data.
- readData  out  PORTS*DATA_WIDTH  per-port registered read data.
- readValid  out  PORTS  high for one cycle when readData[p] carries a fresh result.
- collision  out  PORTS  present only with MEM_COLLISION_DETECT_EN (see Configuration).

## Operation

- States: INIT and RUN.
- Reset asserted:
  - Enter INIT with the sweep counter at 0.
  - ready=0, readData=0, readValid=0, collision=0.
  - Array contents are not cleared by reset itself.
- INIT:
  - Write INIT_VALUE to address counter[ADDR_WIDTH-1:0] each cycle.
  - After address 2**ADDR_WIDTH-1 is written, move to RUN.
  - All port requests are ignored; readValid stays 0.
- RUN:
  - Each port is independent and may read and write in the same cycle.
- Write:
  - If writeEnable[p], word address[p] takes writeData[p] at the clock edge.
- Write collision:
  - When two or more ports write the same address in one cycle, the lowest-index port wins.
  - The other writes to that address are discarded.
- Read:
  - If readEnable[p], readData[p] registers the word at address[p].
  - readValid[p]=1 in the following cycle; otherwise readData[p] holds and readValid[p]=0.
- Read-during-write, same or different port, same address, same cycle:
  - WRITE_FIRST=1: return the winning write data.
  - WRITE_FIRST=0: return the pre-write contents.
- Reset mid-INIT or mid-RUN:
  - Return immediately to INIT.
  - The sweep restarts at address 0.
  - Outputs drop to their reset values.

## Timing

- Read latency is 1 cycle: request at edge N, readData/readValid valid after edge N+1.
- Back-to-back reads on every cycle are supported with no bubbles.
- Write is visible to any read issued on the next cycle.
- The INIT sweep lasts exactly 2**ADDR_WIDTH cycles after reset deasserts.
  - ready rises on the edge that completes the last init write.
  - The first accepted request is in the cycle ready is high.
- Requests made while ready=0 are dropped, not queued.

## Configuration

- MEM_COLLISION_DETECT_EN defined:
  - collision[p] pulses high for one cycle, registered, after a cycle in which port p's write was discarded by a lower-index port writing the same address.
  - The winning port's bit stays 0.
  - collision resets to 0.
- MEM_COLLISION_DETECT_EN undefined:
  - The collision port and its logic are absent.
  - Arbitration behaviour is identical.

## Test plan

- Reset then idle, ADDR_WIDTH=4, INIT_VALUE=8'hA5: ready rises exactly 16 cycles after reset falls; reading all 16 addresses returns 8'hA5 with readValid one cycle after each request.
- Write port0 addr 3 = 8'h11, next cycle read port1 addr 3: readData[1]=8'h11 and readValid[1]=1 one cycle later.
- Same cycle, port0 and port1 both write addr 7 (8'h22, 8'h33), then read: 8'h22 stored; with the macro, collision=2'b10 for one cycle.
- Addr 5 holds 8'h44; port0 writes 8'h55 while port1 reads addr 5: WRITE_FIRST=0 returns 8'h44, WRITE_FIRST=1 returns 8'h55.
- Reset asserted during cycle 8 of INIT: outputs clear immediately; after release the sweep reruns the full 16 cycles before ready=1.
- Requests issued with ready=0: no array change and readValid stays 0.

Source files
------------

// File: rtl/multi_port_sync_mem_if.sv
// Per-port request/response bundle for multi_port_sync_mem, one slice per port in each vector.
// The collision vector exists only when MEM_COLLISION_DETECT_EN is defined.
interface multi_port_sync_mem_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PORTS      = 2
);
    logic                          ready;
    logic [PORTS-1:0]              writeEnable;
    logic [PORTS-1:0]              readEnable;
    logic [PORTS*ADDR_WIDTH-1:0]   address;
    logic [PORTS*DATA_WIDTH-1:0]   writeData;
    logic [PORTS*DATA_WIDTH-1:0]   readData;
    logic [PORTS-1:0]              readValid;
`ifdef MEM_COLLISION_DETECT_EN
    logic [PORTS-1:0]              collision;

    modport master (
        output writeEnable, readEnable, address, writeData,
        input  ready, readData, readValid, collision
    );
    modport slave (
        input  writeEnable, readEnable, address, writeData,
        output ready, readData, readValid, collision
    );
`else
    modport master (
        output writeEnable, readEnable, address, writeData,
        input  ready, readData, readValid
    );
    modport slave (
        input  writeEnable, readEnable, address, writeData,
        output ready, readData, readValid
    );
`endif
endinterface

// File: rtl/multi_port_sync_mem.sv
// N-port synchronous RAM with post-reset init sweep, lowest-port-wins write arbitration and
// selectable read-during-write; MEM_COLLISION_DETECT_EN adds the registered collision vector.
module multi_port_sync_mem #(
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PORTS       = 2,
    parameter int                    WRITE_FIRST = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input logic                  clock,
    input logic                  reset,
    multi_port_sync_mem_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   sweep;
    logic                    sweep_done;
    logic                    run;
    logic                    init_write;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   port_addr  [PORTS];
    logic [DATA_WIDTH-1:0]   port_wdata [PORTS];
    logic [DATA_WIDTH-1:0]   read_word  [PORTS];
    logic [PORTS-1:0]        write_win;
    logic [PORTS*DATA_WIDTH-1:0] read_data_q;
    logic [PORTS-1:0]        read_valid_q;

    for (genvar p = 0; p < PORTS; p++) begin : g_unpack
        assign port_addr[p]  = bus.address[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_wdata[p] = bus.writeData[p*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sweep_done = &sweep;

    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_next;
            if (init_write) sweep <= sweep + 1'b1;
        end
    end

    // NOTE: defaulting state_next before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (sweep_done) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        run        = (state == RUN);
        init_write = (state == INIT);
        bus.ready  = run;
    end

    // A write wins unless a lower-index port writes the same word in the same cycle.
    always_comb begin
        write_win = '0;
        for (int p = 0; p < PORTS; p++) begin
            write_win[p] = run && bus.writeEnable[p];
            for (int q = 0; q < p; q++) begin
                if (bus.writeEnable[q] && (port_addr[q] == port_addr[p])) write_win[p] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            read_word[p] = mem[port_addr[p]];
            if (WRITE_FIRST != 0) begin
                for (int q = 0; q < PORTS; q++) begin
                    if (write_win[q] && (port_addr[q] == port_addr[p])) read_word[p] = port_wdata[q];
                end
            end
        end
    end

    // NOTE: the array has no reset; the init sweep defines its contents, which keeps it RAM-mappable.
    always_ff @(posedge clock) begin
        if (init_write) mem[sweep] <= INIT_VALUE;
        for (int p = 0; p < PORTS; p++) begin
            if (write_win[p]) mem[port_addr[p]] <= port_wdata[p];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data_q  <= '0;
            read_valid_q <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                read_valid_q[p] <= run && bus.readEnable[p];
                if (run && bus.readEnable[p]) read_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= read_word[p];
            end
        end
    end

    assign bus.readData  = read_data_q;
    assign bus.readValid = read_valid_q;

`ifdef MEM_COLLISION_DETECT_EN
    logic [PORTS-1:0] collision_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) collision_q <= '0;
        else       collision_q <= run ? (bus.writeEnable & ~write_win) : '0;
    end

    assign bus.collision = collision_q;
`endif
endmodule
